// File: rtl/edge_pulse_pkg.sv
// Shared types and limits for the multi-channel edge-to-pulse converter.
package edge_pulse_pkg;

  typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_mode_e;

  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} edge_state_e;

  localparam int MAX_DEBOUNCE = 65535;

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchroniser chain, debounce counter/FSM and level register.
// rise_o/fall_o are same-cycle acceptance strobes; the top registers them.
module edge_channel
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc_s;
  edge_state_e            state_q, state_d;
  logic                   level_q, level_d;
  logic                   sync_s, differ_s, accept_s;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], in_i};
  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign differ_s  = sync_s ^ level_q;
  assign cnt_inc_s = cnt_q + CW'(1);
  // Counter never exceeds DEBOUNCE-1, so the increment cannot wrap.
  assign accept_s  = differ_s && (cnt_inc_s == CNT_LAST);

  // State register: sync chain, counter, FSM state and debounced level.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      cnt_q   <= {CW{1'b0}};
      state_q <= STABLE_LO;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Next-state logic for the debounce FSM and its counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STABLE_LO: if (sync_s)   state_d = accept_s ? STABLE_HI : PEND_HI;
                 else          state_d = STABLE_LO;
      PEND_HI:   if (!sync_s)  state_d = STABLE_LO;
                 else if (accept_s) state_d = STABLE_HI;
                 else          state_d = PEND_HI;
      STABLE_HI: if (!sync_s)  state_d = accept_s ? STABLE_LO : PEND_LO;
                 else          state_d = STABLE_HI;
      PEND_LO:   if (sync_s)   state_d = STABLE_HI;
                 else if (accept_s) state_d = STABLE_LO;
                 else          state_d = PEND_LO;
      default:                 state_d = STABLE_LO;
    endcase
    if (!differ_s || accept_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_inc_s;
    end
  end

  // Output logic: level flips and one strobe fires on the acceptance sample.
  always_comb begin
    if (accept_s) begin
      level_d = ~level_q;
    end else begin
      level_d = level_q;
    end
    rise_o = accept_s & ~level_q;
    fall_o = accept_s & level_q;
  end

  assign level_o = level_q;

endmodule

// File: rtl/edge_pulse_multi.sv
// Multi-channel debounced edge-to-pulse converter with enable masking and
// MODE-selected pulse output; all outputs come straight from flops.
module edge_pulse_multi
  import edge_pulse_pkg::*;
#(
  parameter int         CHANNELS    = 4,
  parameter int         SYNC_STAGES = 2,
  parameter int         DEBOUNCE    = 4,
  parameter edge_mode_e MODE        = EDGE_RISE
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  input  logic                enable,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] pulse,
  output logic                any
);

  logic [CHANNELS-1:0] rise_s, fall_s;
  logic [CHANNELS-1:0] rise_d, fall_d, pulse_d;
  logic [CHANNELS-1:0] rise_q, fall_q, pulse_q;
  logic                any_d, any_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    edge_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_chan (
      .clock_i (clock),
      .reset_ni(reset_n),
      .in_i    (in[g]),
      .level_o (level[g]),
      .rise_o  (rise_s[g]),
      .fall_o  (fall_s[g])
    );
  end

  // Enable masking and mode selection of the acceptance strobes.
  always_comb begin
    if (enable) begin
      rise_d = rise_s;
      fall_d = fall_s;
    end else begin
      rise_d = {CHANNELS{1'b0}};
      fall_d = {CHANNELS{1'b0}};
    end
    case (MODE)
      EDGE_RISE: pulse_d = rise_d;
      EDGE_FALL: pulse_d = fall_d;
      EDGE_BOTH: pulse_d = rise_d | fall_d;
      default:   pulse_d = {CHANNELS{1'b0}};
    endcase
    any_d = |pulse_d;
  end

  // Pulse output registers, aligned with the level flip inside each channel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rise_q  <= {CHANNELS{1'b0}};
      fall_q  <= {CHANNELS{1'b0}};
      pulse_q <= {CHANNELS{1'b0}};
      any_q   <= 1'b0;
    end else begin
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pulse_q <= pulse_d;
      any_q   <= any_d;
    end
  end

  assign rise  = rise_q;
  assign fall  = fall_q;
  assign pulse = pulse_q;
  assign any   = any_q;

endmodule
